// File: rtl/i_miss_queue_pkg.sv
// ----------------------------------------------------------------------------
// i_miss_queue_pkg
// Shared instruction-fetch definitions used by the miss queue and its users:
//   MEM_TAG        - memory request tag, 0 means "no tag / no return"
//   I_ADDR         - 32-bit instruction address
//   I_TAG          - cache-line tag field of an I_ADDR (bits [15:3])
//   I_ADDR_PACKET  - {valid, addr} address bundle
//   MSHR_PACKET    - one outstanding-miss entry {valid, mem_tag, i_tag}
// No ports (package).
// ----------------------------------------------------------------------------
package i_miss_queue_pkg;

  localparam int NUM_MEM_TAGS = 8;
  localparam int MEM_TAG_W    = 4;
  localparam int I_TAG_LSB    = 3;
  localparam int I_TAG_W      = 13;

  typedef logic [MEM_TAG_W-1:0] MEM_TAG;
  typedef logic [31:0]          I_ADDR;
  typedef logic [I_TAG_W-1:0]   I_TAG;

  typedef struct packed {
    logic  valid;
    I_ADDR addr;
  } I_ADDR_PACKET;

  typedef struct packed {
    logic   valid;
    MEM_TAG mem_tag;
    I_TAG   i_tag;
  } MSHR_PACKET;

  // Rebuild the icache line address from a stored tag: upper half and block
  // offset are always zero.
  function automatic I_ADDR line_addr(input I_TAG tag);
    return {16'b0, tag, 3'b0};
  endfunction

endpackage

// File: rtl/psel_gen.sv
// ----------------------------------------------------------------------------
// psel_gen - lowest-index-first priority selector.
// Grants up to REQS requests per cycle, each to the lowest remaining set bit.
//   req [WIDTH] : request vector
//   gnt [WIDTH] : OR of all grants (one-hot when REQS=1)
// ----------------------------------------------------------------------------
module psel_gen #(
  parameter int WIDTH = 4,
  parameter int REQS  = 1
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt
);

  always_comb begin
    logic [WIDTH-1:0] remaining;
    logic [WIDTH-1:0] pick;
    remaining = req;
    pick      = '0;
    gnt       = '0;
    for (int r = 0; r < REQS; r++) begin
      // Two's-complement trick isolates the lowest set bit.
      pick      = remaining & (~remaining + WIDTH'(1));
      gnt       = gnt | pick;
      remaining = remaining & ~pick;
    end
  end

endmodule

// File: rtl/i_miss_queue.sv
// ----------------------------------------------------------------------------
// i_miss_queue - outstanding instruction-miss tracker (MSHR list).
// Records accepted memory requests {mem_tag, i_tag}, answers snoop lookups
// ("line already pending"), and converts returning memory tags into icache
// fill addresses.
//
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   snoop_addrs[SP]     : lookup addresses; snoop_hits[SP] per-port hit
//   alloc_valid/tag/addr: record an accepted request; alloc_ready = not full
//   mem_data_tag        : returning data tag (0 = none)
//   fill_addr           : icache write address for the returning data
//   flush               : drop every pending entry
//   count               : number of valid entries
//
// Build option: define I_MISS_QUEUE_OOO_EN for out-of-order returns (any
// valid entry may match, allocation into the lowest free slot). Default is a
// circular FIFO where only the head entry may be filled.
// ----------------------------------------------------------------------------
module i_miss_queue
  import i_miss_queue_pkg::*;
#(
  parameter int DEPTH       = NUM_MEM_TAGS,
  parameter int SNOOP_PORTS = 2
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  I_ADDR_PACKET [SNOOP_PORTS-1:0]       snoop_addrs,
  output logic [SNOOP_PORTS-1:0]               snoop_hits,
  input  logic                                 alloc_valid,
  input  MEM_TAG                               alloc_tag,
  input  I_ADDR                                alloc_addr,
  output logic                                 alloc_ready,
  input  MEM_TAG                               mem_data_tag,
  output I_ADDR_PACKET                         fill_addr,
  input  logic                                 flush,
  output logic [$clog2(DEPTH+1)-1:0]           count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  MSHR_PACKET       entries_reg [DEPTH];
  logic [CW-1:0]    count_reg;
  logic [DEPTH-1:0] valid_vec;
  logic [DEPTH-1:0] tag_match;
  logic [DEPTH-1:0] eligible;
  logic             not_full;
  logic             alloc_fire;
  logic             fill_hit;
  logic [IW-1:0]    alloc_idx;
  logic [IW-1:0]    fill_idx;
  I_TAG             alloc_i_tag;
  logic             unused_alloc_bits;

  assign alloc_i_tag       = alloc_addr[I_TAG_LSB +: I_TAG_W];
  assign unused_alloc_bits = ^{alloc_addr[31:16], alloc_addr[2:0]};

  // Outputs read as idle while reset is held, even if state is still stale.
  assign not_full    = (count_reg != CW'(DEPTH));
  assign alloc_ready = reset | not_full;
  assign alloc_fire  = alloc_valid & not_full & ~flush & ~reset;
  assign count       = reset ? '0 : count_reg;

  // Fill-side CAM: a zero return tag never matches anything.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fill_cam
      assign valid_vec[gi] = entries_reg[gi].valid;
      assign tag_match[gi] = valid_vec[gi] & (mem_data_tag != '0) &
                             (entries_reg[gi].mem_tag == mem_data_tag);
    end
  endgenerate

`ifdef I_MISS_QUEUE_OOO_EN
  logic [DEPTH-1:0] free_gnt;

  psel_gen #(
    .WIDTH (DEPTH),
    .REQS  (1)
  ) u_free_sel (
    .req (~valid_vec),
    .gnt (free_gnt)
  );

  assign eligible = tag_match;

  always_comb begin
    alloc_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (free_gnt[i]) alloc_idx = alloc_idx | IW'(i);
    end
  end
`else
  logic [IW-1:0] head_reg;
  logic [IW-1:0] tail_reg;

  // In-order mode: a return that is not for the head entry is ignored.
  always_comb begin
    eligible           = '0;
    eligible[head_reg] = tag_match[head_reg];
  end

  assign alloc_idx = tail_reg;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      if (alloc_fire) tail_reg <= tail_reg + IW'(1);
      if (fill_hit)   head_reg <= head_reg + IW'(1);
    end
  end
`endif

  // Lowest eligible index wins when several entries share a memory tag.
  always_comb begin
    fill_hit = 1'b0;
    fill_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (eligible[i] && !flush && !reset) begin
        fill_hit = 1'b1;
        fill_idx = IW'(i);
      end
    end
  end

  always_comb begin
    fill_addr = '0;
    if (fill_hit) begin
      fill_addr.valid = 1'b1;
      fill_addr.addr  = line_addr(entries_reg[fill_idx].i_tag);
    end
  end

  // Snoop-side CAM: pending entries plus the allocation accepted this cycle.
  generate
    for (genvar gi = 0; gi < SNOOP_PORTS; gi++) begin : g_snoop
      I_TAG             snoop_tag;
      logic [DEPTH-1:0] cam_hit;
      logic             unused_snoop_bits;

      assign snoop_tag         = snoop_addrs[gi].addr[I_TAG_LSB +: I_TAG_W];
      assign unused_snoop_bits = ^{snoop_addrs[gi].addr[31:16], snoop_addrs[gi].addr[2:0]};

      for (genvar gj = 0; gj < DEPTH; gj++) begin : g_entry
        assign cam_hit[gj] = valid_vec[gj] & (entries_reg[gj].i_tag == snoop_tag);
      end

      assign snoop_hits[gi] = ~reset & snoop_addrs[gi].valid &
                              ((|cam_hit) | (alloc_fire & (alloc_i_tag == snoop_tag)));
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) entries_reg[i] <= '0;
    end else if (flush) begin
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) entries_reg[i].valid <= 1'b0;
    end else begin
      // Alloc slot is always free and fill slot always valid, so they differ.
      if (alloc_fire) begin
        entries_reg[alloc_idx].valid   <= 1'b1;
        entries_reg[alloc_idx].mem_tag <= alloc_tag;
        entries_reg[alloc_idx].i_tag   <= alloc_i_tag;
      end
      if (fill_hit) entries_reg[fill_idx].valid <= 1'b0;
      count_reg <= count_reg + CW'(alloc_fire) - CW'(fill_hit);
    end
  end

endmodule

// File: tb/tb_i_miss_queue.sv
`timescale 1ns/1ps
module tb_i_miss_queue;
  import i_miss_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int SP    = 2;

  logic               clock = 1'b0;
  logic               reset;
  I_ADDR_PACKET [SP-1:0] snoop_addrs;
  logic [SP-1:0]      snoop_hits;
  logic               alloc_valid;
  MEM_TAG             alloc_tag;
  I_ADDR              alloc_addr;
  logic               alloc_ready;
  MEM_TAG             mem_data_tag;
  I_ADDR_PACKET       fill_addr;
  logic               flush;
  logic [2:0]         count;

  always #5 clock = ~clock;

  i_miss_queue #(.DEPTH(DEPTH), .SNOOP_PORTS(SP)) dut (
    .clock        (clock),
    .reset        (reset),
    .snoop_addrs  (snoop_addrs),
    .snoop_hits   (snoop_hits),
    .alloc_valid  (alloc_valid),
    .alloc_tag    (alloc_tag),
    .alloc_addr   (alloc_addr),
    .alloc_ready  (alloc_ready),
    .mem_data_tag (mem_data_tag),
    .fill_addr    (fill_addr),
    .flush        (flush),
    .count        (count)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic   rst;
    logic   fl;
    logic   av;
    MEM_TAG at;
    I_ADDR  aa;
    MEM_TAG mt;
    logic   s0v;
    I_ADDR  s0;
    logic   s1v;
    I_ADDR  s1;
    logic       e_ready;
    logic [1:0] e_hits;
    logic       e_fv;
    I_ADDR      e_fa;
    logic [2:0] e_count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic fl, input logic av,
                              input MEM_TAG at, input I_ADDR aa, input MEM_TAG mt,
                              input logic s0v, input I_ADDR s0, input logic s1v, input I_ADDR s1,
                              input logic e_ready, input logic [1:0] e_hits,
                              input logic e_fv, input I_ADDR e_fa, input logic [2:0] e_count);
    vec_t v;
    v.rst = rst; v.fl = fl; v.av = av; v.at = at; v.aa = aa; v.mt = mt;
    v.s0v = s0v; v.s0 = s0; v.s1v = s1v; v.s1 = s1;
    v.e_ready = e_ready; v.e_hits = e_hits; v.e_fv = e_fv; v.e_fa = e_fa; v.e_count = e_count;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic av, input MEM_TAG at,
                       input I_ADDR aa, input MEM_TAG mt, input logic s0v, input I_ADDR s0,
                       input logic s1v, input I_ADDR s1);
    reset              = rst;
    flush              = fl;
    alloc_valid        = av;
    alloc_tag          = at;
    alloc_addr         = aa;
    mem_data_tag       = mt;
    snoop_addrs[0].valid = s0v;
    snoop_addrs[0].addr  = s0;
    snoop_addrs[1].valid = s1v;
    snoop_addrs[1].addr  = s1;
  endtask

  // Drive at negedge, sample 1 ns later (well before the next posedge).
  task automatic apply_vec(input vec_t v, input string name);
    I_ADDR_PACKET e_fill;
    @(negedge clock);
    drive(v.rst, v.fl, v.av, v.at, v.aa, v.mt, v.s0v, v.s0, v.s1v, v.s1);
    #1;
    e_fill.valid = v.e_fv;
    e_fill.addr  = v.e_fa;
    chk({name, ".alloc_ready"}, 64'(alloc_ready), 64'(v.e_ready));
    chk({name, ".snoop_hits"},  64'(snoop_hits),  64'(v.e_hits));
    chk({name, ".fill_addr"},   64'(fill_addr),   64'(e_fill));
    chk({name, ".count"},       64'(count),       64'(v.e_count));
    $display("%s rst=%b fl=%b av=%b at=%0d mt=%0d -> ready=%b hits=%b fill=%b/%h count=%0d",
             name, v.rst, v.fl, v.av, v.at, v.mt, alloc_ready, snoop_hits,
             fill_addr.valid, fill_addr.addr, count);
  endtask

  // ---------------- behavioural reference model ----------------
`ifdef I_MISS_QUEUE_OOO_EN
  bit     m_v  [DEPTH];
  MEM_TAG m_mt [DEPTH];
  I_TAG   m_it [DEPTH];
`else
  typedef struct { MEM_TAG mt; I_TAG it; } ent_t;
  ent_t m_q[$];
`endif

  function automatic I_TAG tag_of(input I_ADDR a);
    return I_TAG'((a >> 3) & 32'h1fff);
  endfunction

  function automatic int m_count();
`ifdef I_MISS_QUEUE_OOO_EN
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m_v[i]) c++;
    return c;
`else
    return m_q.size();
`endif
  endfunction

  function automatic bit m_pending(input I_TAG t);
`ifdef I_MISS_QUEUE_OOO_EN
    for (int i = 0; i < DEPTH; i++) if (m_v[i] && m_it[i] == t) return 1'b1;
`else
    foreach (m_q[i]) if (m_q[i].it == t) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic MEM_TAG m_some_tag();
`ifdef I_MISS_QUEUE_OOO_EN
    for (int k = 0; k < 8; k++) begin
      int i = $urandom_range(DEPTH-1);
      if (m_v[i]) return m_mt[i];
    end
    return MEM_TAG'($urandom_range(15));
`else
    if (m_q.size() == 0) return '0;
    if ($urandom_range(1) == 0) return m_q[0].mt;
    return m_q[$urandom_range(m_q.size()-1)].mt;
`endif
  endfunction

  task automatic random_phase(input int n_cycles);
    logic r, fl, av;
    MEM_TAG at, mt;
    I_ADDR aa;
    logic [1:0] sv;
    I_ADDR sa [2];
    int cnt;
    bit acc, fhit;
    I_TAG fit;
    int fidx;
    logic [1:0] e_hits;
    I_ADDR_PACKET e_fill;
    for (int n = 0; n < n_cycles; n++) begin
      r  = (n == 0) || ($urandom_range(99) < 2);
      fl = ($urandom_range(99) < 3);
      av = ($urandom_range(99) < 60);
      at = MEM_TAG'($urandom_range(15, 1));
      aa = {16'b0, 13'($urandom_range(7) + 32), 3'($urandom_range(7))};
      mt = ($urandom_range(1) == 0) ? m_some_tag() : MEM_TAG'($urandom_range(15));
      for (int p = 0; p < 2; p++) begin
        sv[p] = ($urandom_range(3) != 0);
        sa[p] = {16'b0, 13'($urandom_range(7) + 32), 3'($urandom_range(7))};
      end
      @(negedge clock);
      drive(r, fl, av, at, aa, mt, sv[0], sa[0], sv[1], sa[1]);
      #1;
      // Expected outputs from the rules.
      cnt  = m_count();
      acc  = av && !r && !fl && (cnt < DEPTH);
      fhit = 1'b0; fit = '0; fidx = -1;
      if (!r && !fl && mt != 0) begin
`ifdef I_MISS_QUEUE_OOO_EN
        for (int i = 0; i < DEPTH; i++)
          if (!fhit && m_v[i] && m_mt[i] == mt) begin fhit = 1'b1; fit = m_it[i]; fidx = i; end
`else
        if (m_q.size() > 0 && m_q[0].mt == mt) begin fhit = 1'b1; fit = m_q[0].it; end
`endif
      end
      for (int p = 0; p < 2; p++)
        e_hits[p] = !r && sv[p] && (m_pending(tag_of(sa[p])) || (acc && tag_of(aa) == tag_of(sa[p])));
      e_fill.valid = fhit;
      e_fill.addr  = fhit ? (I_ADDR'(fit) * 8) : '0;
      chk("rnd.alloc_ready", 64'(alloc_ready), 64'(r || cnt < DEPTH));
      chk("rnd.snoop_hits",  64'(snoop_hits),  64'(e_hits));
      chk("rnd.fill_addr",   64'(fill_addr),   64'(e_fill));
      chk("rnd.count",       64'(count),       64'(r ? 0 : cnt));
      $display("rnd%0d rst=%b fl=%b av=%b at=%0d mt=%0d -> ready=%b hits=%b fill=%b/%h count=%0d",
               n, r, fl, av, at, mt, alloc_ready, snoop_hits, fill_addr.valid, fill_addr.addr, count);
      // Advance the model to the state after the coming edge.
      if (r || fl) begin
`ifdef I_MISS_QUEUE_OOO_EN
        for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
`else
        m_q.delete();
`endif
      end else begin
`ifdef I_MISS_QUEUE_OOO_EN
        int slot = -1;
        for (int i = DEPTH-1; i >= 0; i--) if (!m_v[i]) slot = i;
        if (fhit) m_v[fidx] = 1'b0;
        if (acc) begin m_v[slot] = 1'b1; m_mt[slot] = at; m_it[slot] = tag_of(aa); end
`else
        ent_t e;
        if (fhit) void'(m_q.pop_front());
        if (acc) begin e.mt = at; e.it = tag_of(aa); m_q.push_back(e); end
`endif
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Directed table: fill, full/drop, snoop, alloc+fill, flush, reset, wrap.
    vecs.push_back(mk(1,0,0,0,0,0,        0,0,0,0,             1,2'b00,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,        0,0,0,0,             1,2'b00,0,0,0));
    vecs.push_back(mk(0,0,1,1,'h100,0,    1,'h100,1,'h108,     1,2'b01,0,0,0));
    vecs.push_back(mk(0,0,1,2,'h108,0,    1,'h100,1,'h108,     1,2'b11,0,0,1));
    vecs.push_back(mk(0,0,1,3,'h110,0,    0,0,0,0,             1,2'b00,0,0,2));
    vecs.push_back(mk(0,0,1,4,'h118,0,    1,'h120,0,0,         1,2'b00,0,0,3));
    vecs.push_back(mk(0,0,1,5,'h120,0,    1,'h120,1,'h108,     0,2'b10,0,0,4));
    vecs.push_back(mk(0,0,0,0,0,0,        1,'h104,0,0,         0,2'b01,0,0,4));
    vecs.push_back(mk(0,0,1,6,'h128,1,    0,0,1,'h128,         0,2'b00,1,'h100,4));
    vecs.push_back(mk(0,0,0,0,0,0,        1,'h100,0,0,         1,2'b00,0,0,3));
    vecs.push_back(mk(0,0,0,0,0,2,        0,0,0,0,             1,2'b00,1,'h108,3));
    vecs.push_back(mk(0,0,1,7,'h130,3,    0,0,0,0,             1,2'b00,1,'h110,2));
    vecs.push_back(mk(0,0,0,0,0,0,        1,'h130,0,0,         1,2'b01,0,0,2));
    vecs.push_back(mk(0,1,1,8,'h138,4,    0,0,0,0,             1,2'b00,0,0,2));
    vecs.push_back(mk(0,0,0,0,0,4,        1,'h118,1,'h138,     1,2'b00,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,7,        0,0,0,0,             1,2'b00,0,0,0));
    vecs.push_back(mk(0,0,1,1,'h200,0,    0,0,0,0,             1,2'b00,0,0,0));
    vecs.push_back(mk(0,0,1,2,'h208,0,    0,0,0,0,             1,2'b00,0,0,1));
    vecs.push_back(mk(1,0,1,3,'h210,1,    1,'h200,0,0,         1,2'b00,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1,        1,'h200,0,0,         1,2'b00,0,0,0));
    vecs.push_back(mk(0,0,1,9,'h300,0,    0,0,0,0,             1,2'b00,0,0,0));
    for (int k = 1; k <= 5; k++)
      vecs.push_back(mk(0,0,1,MEM_TAG'(9+k),I_ADDR'('h300+8*k),MEM_TAG'(8+k),
                        0,0,0,0,             1,2'b00,1,I_ADDR'('h300+8*(k-1)),1));
    vecs.push_back(mk(0,0,0,0,0,14,       0,0,0,0,             1,2'b00,1,'h328,1));
    vecs.push_back(mk(0,0,0,0,0,0,        0,0,0,0,             1,2'b00,0,0,0));

    foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Non-head return: only honoured when out-of-order returns are enabled.
    apply_vec(mk(1,0,0,0,0,0,      0,0,0,0, 1,2'b00,0,0,0), "ooo.rst");
    apply_vec(mk(0,0,1,1,'h100,0,  0,0,0,0, 1,2'b00,0,0,0), "ooo.a1");
    apply_vec(mk(0,0,1,2,'h108,0,  0,0,0,0, 1,2'b00,0,0,1), "ooo.a2");
    apply_vec(mk(0,0,1,3,'h110,0,  0,0,0,0, 1,2'b00,0,0,2), "ooo.a3");
`ifdef I_MISS_QUEUE_OOO_EN
    apply_vec(mk(0,0,0,0,0,3,      0,0,0,0, 1,2'b00,1,'h110,3), "ooo.ret3");
    apply_vec(mk(0,0,0,0,0,0,      1,'h110,1,'h108, 1,2'b10,0,0,2), "ooo.after");
`else
    apply_vec(mk(0,0,0,0,0,3,      0,0,0,0, 1,2'b00,0,0,3), "ooo.ret3");
    apply_vec(mk(0,0,0,0,0,0,      1,'h110,1,'h108, 1,2'b11,0,0,3), "ooo.after");
`endif

    random_phase(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
